// File: rtl/keypad_decoder.sv
// keypad_decoder: scans a 4x6 calculator keypad, debounces press and release,
// and emits one single-cycle event pulse per accepted key with its decoded code.
// Optional build macro: AUTOREPEAT_EN adds hold-to-repeat for hex keys and BS.
module keypad_decoder #(
  parameter int SCAN_TICKS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [5:0] cols,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq,
  output logic       BS
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  // A counter equal to DB_LAST means the next qualifying sample is the final one.
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [3:0] r);
    logic [3:0] low;
    low = ~r;
    return (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
  endfunction

  // Index of the low row in a single-low pattern.
  function automatic logic [1:0] row_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Column sequence 0..5 with wrap.
  function automatic logic [2:0] next_col(input logic [2:0] c);
    logic [2:0] n;
    if (c >= 3'd5) begin
      n = 3'd0;
    end else begin
      n = c + 3'd1;
    end
    return n;
  endfunction

  // One-hot active-low drive pattern for a column index.
  function automatic logic [5:0] col_drive(input logic [2:0] c);
    return ~(6'b000001 << c);
  endfunction

  state_e          state_q;
  logic [2:0]      col_q;
  logic [5:0]      cols_q;
  logic [TW-1:0]   tick_q;
  logic [3:0]      row_q;
  logic [DW-1:0]   match_q;
  logic [DW-1:0]   rel_q;
  logic            newhex_q;
  logic [3:0]      hexcode_q;
  logic            newop_q;
  logic [1:0]      opcode_q;
  logic            eq_q;
  logic            bs_q;
`ifdef AUTOREPEAT_EN
  logic [RW-1:0]   rpt_cnt_q;
  logic            rpt_first_q;
`endif

  logic [1:0]      key_row_s;
  logic            is_hex_s;
  logic            is_op_s;
  logic            is_eq_s;
  logic            is_bs_s;
  logic [3:0]      key_hex_s;
  logic [2:0]      col_next_s;

  // Classify the latched key (row_q, col_q) according to the keypad map.
  always_comb begin
    key_row_s  = row_index(row_q);
    is_hex_s   = 1'b0;
    is_op_s    = 1'b0;
    is_eq_s    = 1'b0;
    is_bs_s    = 1'b0;
    key_hex_s  = {key_row_s, col_q[1:0]};
    col_next_s = next_col(col_q);
    if (col_q < 3'd4) begin
      is_hex_s = 1'b1;
    end else if (col_q == 3'd4) begin
      if (key_row_s == 2'd3) begin
        is_eq_s = 1'b1;
      end else begin
        is_op_s = 1'b1;
      end
    end else begin
      // Column 5: only row 0 (backspace) is populated; rows 1-3 are dead keys.
      is_bs_s = (key_row_s == 2'd0);
    end
  end

  // Scan / debounce / held state machine with registered event outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      col_q       <= 3'd0;
      cols_q      <= 6'b111110;
      tick_q      <= '0;
      row_q       <= 4'b1111;
      match_q     <= '0;
      rel_q       <= '0;
      newhex_q    <= 1'b0;
      hexcode_q   <= 4'h0;
      newop_q     <= 1'b0;
      opcode_q    <= 2'b00;
      eq_q        <= 1'b0;
      bs_q        <= 1'b0;
`ifdef AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      // Event pulses last exactly one cycle unless re-fired below.
      newhex_q <= 1'b0;
      newop_q  <= 1'b0;
      eq_q     <= 1'b0;
      bs_q     <= 1'b0;

      case (state_q)
        ST_SCAN: begin
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (single_low(rows)) begin
              // The detection sample itself is the first match.
              row_q   <= rows;
              match_q <= DW'(1);
              state_q <= ST_DEBOUNCE;
            end else begin
              col_q  <= col_next_s;
              cols_q <= col_drive(col_next_s);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (rows == row_q) begin
            if (match_q == DB_LAST) begin
              state_q  <= ST_HELD;
              rel_q    <= '0;
              newhex_q <= is_hex_s;
              newop_q  <= is_op_s;
              eq_q     <= is_eq_s;
              bs_q     <= is_bs_s;
              if (is_hex_s) begin
                hexcode_q <= key_hex_s;
              end else begin
                hexcode_q <= hexcode_q;
              end
              if (is_op_s) begin
                opcode_q <= key_row_s;
              end else begin
                opcode_q <= opcode_q;
              end
`ifdef AUTOREPEAT_EN
              rpt_cnt_q   <= '0;
              rpt_first_q <= 1'b1;
`endif
            end else begin
              match_q <= match_q + DW'(1);
            end
          end else begin
            // Bounce or a different pattern: abandon without an event.
            state_q <= ST_SCAN;
            tick_q  <= '0;
            match_q <= '0;
            col_q   <= col_next_s;
            cols_q  <= col_drive(col_next_s);
          end
        end

        ST_HELD: begin
          if (rows == 4'b1111) begin
            if (rel_q == DB_LAST) begin
              state_q <= ST_SCAN;
              tick_q  <= '0;
              rel_q   <= '0;
              match_q <= '0;
              col_q   <= col_next_s;
              cols_q  <= col_drive(col_next_s);
            end else begin
              rel_q <= rel_q + DW'(1);
            end
          end else begin
            // Any low row (the held key or rollover keys) restarts release timing.
            rel_q <= '0;
`ifdef AUTOREPEAT_EN
            if (is_hex_s || is_bs_s) begin
              if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b0;
                newhex_q    <= is_hex_s;
                bs_q        <= is_bs_s;
              end else begin
                rpt_cnt_q <= rpt_cnt_q + RW'(1);
              end
            end else begin
              rpt_cnt_q <= rpt_cnt_q;
            end
`endif
          end
        end

        default: begin
          state_q <= ST_SCAN;
          tick_q  <= '0;
          col_q   <= 3'd0;
          cols_q  <= 6'b111110;
          match_q <= '0;
          rel_q   <= '0;
        end
      endcase
    end
  end

  assign cols    = cols_q;
  assign newhex  = newhex_q;
  assign hexcode = hexcode_q;
  assign newop   = newop_q;
  assign opcode  = opcode_q;
  assign eq      = eq_q;
  assign BS      = bs_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder: a keypad model drives rows from cols,
// stimulus pushes expected events, a monitor pops and compares on each pulse.
module tb_keypad_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [5:0] cols;
  logic       newhex;
  logic [3:0] hexcode;
  logic       newop;
  logic [1:0] opcode;
  logic       eq;
  logic       BS;

  keypad_decoder dut (
    .clock  (clock),
    .reset  (reset),
    .rows   (rows),
    .cols   (cols),
    .newhex (newhex),
    .hexcode(hexcode),
    .newop  (newop),
    .opcode (opcode),
    .eq     (eq),
    .BS     (BS)
  );

  always #5 clock = ~clock;

  // Physical switch matrix: bit r*6+c is key (r,c) closed.
  logic [23:0] keys = 24'd0;

  // A closed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (keys[r*6+c] && (cols[c] === 1'b0)) rows[r] = 1'b0;
      end
    end
  end

  // kind: 0 hex, 1 operator, 2 equals, 3 backspace
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] code;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] model_hex = 4'h0;
  logic [1:0] model_op  = 2'b00;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Keypad map from the key layout rules.
  function automatic bit key_event(input int r, input int c, output exp_t e);
    e = '0;
    if (c < 4) begin
      e.kind = 2'd0; e.code = 4'(r * 4 + c); return 1'b1;
    end
    if (c == 4) begin
      if (r == 3) begin e.kind = 2'd2; return 1'b1; end
      e.kind = 2'd1; e.code = 4'(r); return 1'b1;
    end
    if (r == 0) begin e.kind = 2'd3; return 1'b1; end
    return 1'b0;
  endfunction

  // Monitor: every pulse must be single, expected, and carry the right codes.
  always @(negedge clock) begin
    int   n;
    exp_t e;
    logic [1:0] act_kind;
    logic [3:0] req_hex;
    logic [1:0] req_op;
    if (reset) begin
      model_hex = 4'h0;
      model_op  = 2'b00;
    end else begin
      n = int'(newhex) + int'(newop) + int'(eq) + int'(BS);
      if (n != 0) begin
        check("single_pulse", n, 1);
        act_kind = newhex ? 2'd0 : (newop ? 2'd1 : (eq ? 2'd2 : 2'd3));
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d hex %0h op %0d, expected no event",
                   act_kind, hexcode, opcode);
        end else begin
          e = sb_q.pop_front();
          req_hex = (e.kind == 2'd0) ? e.code : model_hex;
          req_op  = (e.kind == 2'd1) ? e.code[1:0] : model_op;
          check("event", {act_kind, hexcode, opcode}, {e.kind, req_hex, req_op});
          model_hex = req_hex;
          model_op  = req_op;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Press one key (optionally bouncing first), hold, confirm event, release.
  task automatic press(input int r, input int c, input int hold, input int gap, input bit bounce);
    exp_t e;
    int   idx;
    idx = r * 6 + c;
    if (key_event(r, c, e)) sb_q.push_back(e);
    if (bounce) begin
      for (int i = 0; i < 6; i++) begin
        keys[idx] = (i % 2 == 0);
        cyc(2);
      end
    end
    keys[idx] = 1'b1;
    cyc(hold);
    check("event_latency", sb_q.size(), 0);
    keys[idx] = 1'b0;
    cyc(gap);
  endtask

  // Observe cols for n cycles: must stay one-hot low and visit every column.
  task automatic scan_window(input int n);
    logic [5:0] seen;
    int         bad;
    seen = 6'd0;
    bad  = 0;
    repeat (n) begin
      @(negedge clock);
      seen = seen | ~cols;
      if (!(cols == 6'b111110 || cols == 6'b111101 || cols == 6'b111011 ||
            cols == 6'b110111 || cols == 6'b101111 || cols == 6'b011111)) bad++;
    end
    check("cols_onehot", bad, 0);
    check("scan_cover", seen, 6'h3F);
    @(posedge clock);
    #1;
  endtask

  initial begin
    exp_t e;
    int   r, c;
    reset = 1'b1;
    cyc(3);
    check("reset_state", {cols, newhex, newop, eq, BS, hexcode, opcode},
          {6'b111110, 4'b0000, 4'h0, 2'b00});
    reset = 1'b0;

    // Steady press, then scanning resumes after release.
    press(0, 3, 60, 12, 1'b0);
    scan_window(30);
    // Bouncing press followed by a steady hold.
    press(1, 2, 45, 12, 1'b1);
    // Operator then equals.
    press(1, 4, 45, 12, 1'b0);
    press(3, 4, 45, 12, 1'b0);
    // Backspace and a dead key.
    press(0, 5, 45, 12, 1'b0);
    press(2, 5, 45, 12, 1'b0);
    // Two rows low together in column 1: no key, scan keeps moving.
    keys[0*6+1] = 1'b1;
    keys[2*6+1] = 1'b1;
    scan_window(40);
    keys = 24'd0;
    cyc(12);

    // Reset while holding r3c3, key kept down through reset.
    void'(key_event(3, 3, e));
    sb_q.push_back(e);
    keys[3*6+3] = 1'b1;
    cyc(40);
    check("event_latency", sb_q.size(), 0);
    sb_q.push_back(e);
    reset = 1'b1;
    cyc(2);
    check("reset_while_held", {cols, newhex, newop, eq, BS, hexcode, opcode},
          {6'b111110, 4'b0000, 4'h0, 2'b00});
    reset = 1'b0;
    cyc(40);
    check("event_latency", sb_q.size(), 0);
    keys = 24'd0;
    cyc(15);

    // Randomized presses over the whole matrix.
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(3, 0);
      c = $urandom_range(5, 0);
      press(r, c, 40 + $urandom_range(20, 0), 12 + $urandom_range(10, 0),
            1'($urandom_range(1, 0)));
    end

    scan_window(30);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
